// File: rtl/ram_inst_arbiter.sv
// ram_inst_arbiter: shares one single-port instruction RAM between CPU fetch and the program loader
module ram_inst_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int FETCH_PRIORITY = 0
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              f_req_valid,
  output logic              f_req_ready,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_rsp_valid,
  output logic [DATA_W-1:0] f_rsp_data,
  input  logic              l_req_valid,
  output logic              l_req_ready,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic              l_we,
  input  logic [DATA_W-1:0] l_wdata,
  input  logic              l_lock,
  output logic              l_rsp_valid,
  output logic [DATA_W-1:0] l_rsp_data,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [DATA_W-1:0] ram_dina,
  output logic              ram_wea,
  input  logic [DATA_W-1:0] ram_douta,
  input  logic              stall_clr,
  output logic [15:0]       stall_cnt,
  output logic              locked
);
  typedef enum logic {ARB, LOCK} state_t;
  state_t state, state_nx;
  logic last_l;
  logic gf, gl;
  localparam logic RR = (FETCH_PRIORITY == 0);
  // in LOCK only the loader may win; otherwise the loader wins ties only in round-robin after a fetch grant
  assign gl = !rsta && l_req_valid && (state == LOCK || !f_req_valid || (RR && !last_l));
  assign gf = !rsta && f_req_valid && state == ARB && !gl;
  assign f_req_ready = gf;
  assign l_req_ready = gl;
  assign ram_addra = gl ? l_addr : f_addr;
  assign ram_dina = l_wdata;
  assign ram_wea = gl && l_we;
  assign locked = state == LOCK;
  always_comb begin
    state_nx = state;
    state_nx = gl ? (l_lock ? LOCK : ARB) : state;
  end
  always_ff @(posedge clka) begin
    if (rsta) state <= ARB;
    else state <= state_nx;
  end
  always_ff @(posedge clka) begin
    if (rsta) begin
      last_l <= 1'b1;
      f_rsp_valid <= 1'b0;
      l_rsp_valid <= 1'b0;
      f_rsp_data <= '0;
      l_rsp_data <= '0;
      stall_cnt <= '0;
    end else begin
      f_rsp_valid <= gf;
      l_rsp_valid <= gl;
      if (gf) f_rsp_data <= ram_douta;
      if (gl) l_rsp_data <= ram_douta;
      if (gf || gl) last_l <= gl;
      stall_cnt <= stall_clr ? '0 : (f_req_valid && !gf && !(&stall_cnt)) ? stall_cnt + 16'd1 : stall_cnt;
    end
  end
endmodule

// File: tb/tb_ram_inst_arbiter.sv
// tb_ram_inst_arbiter: directed scoreboard bench for ram_inst_arbiter with a behavioural RAM
module tb_ram_inst_arbiter;
  logic clka = 1'b0;
  logic rsta, f_req_valid, f_req_ready, f_rsp_valid;
  logic l_req_valid, l_req_ready, l_we, l_lock, l_rsp_valid;
  logic ram_wea, stall_clr, locked;
  logic [5:0] f_addr, l_addr, ram_addra;
  logic [31:0] f_rsp_data, l_wdata, l_rsp_data, ram_dina, ram_douta;
  logic [15:0] stall_cnt;
  logic [31:0] mem [64];
  logic [31:0] shadow [64];
  logic [31:0] fq [$];
  logic [31:0] lq [$];
  int cmp = 0;
  int mism = 0;

  always #5 clka = ~clka;

  ram_inst_arbiter dut (
    .clka(clka), .rsta(rsta),
    .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_addr(f_addr),
    .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data),
    .l_req_valid(l_req_valid), .l_req_ready(l_req_ready), .l_addr(l_addr),
    .l_we(l_we), .l_wdata(l_wdata), .l_lock(l_lock),
    .l_rsp_valid(l_rsp_valid), .l_rsp_data(l_rsp_data),
    .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_wea(ram_wea), .ram_douta(ram_douta),
    .stall_clr(stall_clr), .stall_cnt(stall_cnt), .locked(locked)
  );

  assign ram_douta = mem[ram_addra];
  always @(posedge clka) if (ram_wea) mem[ram_addra] <= ram_dina;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clka) begin
    if (f_rsp_valid === 1'b1) begin
      chk("f_rsp_expected", 32'(fq.size() > 0), 32'd1);
      if (fq.size() > 0) chk("f_rsp_data", f_rsp_data, fq.pop_front());
    end
    if (l_rsp_valid === 1'b1) begin
      chk("l_rsp_expected", 32'(lq.size() > 0), 32'd1);
      if (lq.size() > 0) chk("l_rsp_data", l_rsp_data, lq.pop_front());
    end
  end

  task automatic step(input logic r, input logic fv, input logic [5:0] fa,
                      input logic lv, input logic [5:0] la, input logic we, input logic [31:0] wd,
                      input logic lk, input logic clr,
                      input logic efr, input logic elr, input logic elock);
    rsta = r; f_req_valid = fv; f_addr = fa;
    l_req_valid = lv; l_addr = la; l_we = we; l_wdata = wd; l_lock = lk; stall_clr = clr;
    @(negedge clka);
    chk("f_req_ready", 32'(f_req_ready), 32'(efr));
    chk("l_req_ready", 32'(l_req_ready), 32'(elr));
    chk("ram_wea", 32'(ram_wea), 32'(elr & we));
    chk("locked", 32'(locked), 32'(elock));
    if (efr) fq.push_back(shadow[fa]);
    if (elr) begin
      lq.push_back(shadow[la]);
      if (we) shadow[la] = wd;
    end
    @(posedge clka); #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'h0;
      shadow[i] = 32'h0;
    end
    mem[5] = 32'hDEADBEEF;
    shadow[5] = 32'hDEADBEEF;
    rsta = 1'b1; f_req_valid = 1'b1; f_addr = 6'd0; l_req_valid = 1'b1; l_addr = 6'd0;
    l_we = 1'b1; l_wdata = 32'h0; l_lock = 1'b0; stall_clr = 1'b0;
    @(posedge clka); #1;
    // reset gates both grants and any write even with requests pending
    step(1, 1, 6'd3, 1, 6'd3, 1, 32'hBAD0BAD0, 1, 0, 0, 0, 0);
    chk("rst_f_rsp_valid", 32'(f_rsp_valid), 0);
    chk("rst_l_rsp_valid", 32'(l_rsp_valid), 0);
    chk("rst_f_rsp_data", f_rsp_data, 0);
    chk("rst_l_rsp_data", l_rsp_data, 0);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_no_write", mem[3], 0);
    // fetch only
    step(0, 1, 6'd5, 0, 6'd0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 6'd0, 0, 6'd0, 0, 0, 0, 0, 0, 0, 0);
    // loader read so last grant is L, then round-robin F,L,F,L
    step(0, 0, 6'd0, 1, 6'd5, 0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 6'd5, 1, 6'd0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 6'd5, 1, 6'd0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 6'd5, 1, 6'd0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 6'd5, 1, 6'd0, 0, 0, 0, 0, 0, 1, 0);
    chk("rr_stall_cnt", 32'(stall_cnt), 2);
    step(0, 0, 6'd0, 0, 6'd0, 0, 0, 0, 1, 0, 0, 0);
    chk("clr_stall_cnt", 32'(stall_cnt), 0);
    // loader write returns the old word; new word visible to the next fetch
    step(0, 0, 6'd0, 1, 6'd10, 1, 32'h12345678, 0, 0, 0, 1, 0);
    step(0, 1, 6'd10, 0, 6'd0, 0, 0, 0, 0, 1, 0, 0);
    chk("wr_mem", mem[10], 32'h12345678);
    // lock burst against continuous fetch
    for (int i = 0; i < 4; i++)
      step(0, 1, 6'd1, 1, 6'(i), 1, 32'hA0 + 32'(i), (i != 3), 0, 0, 1, (i != 0));
    step(0, 1, 6'd1, 0, 6'd0, 0, 0, 0, 0, 1, 0, 0);
    chk("burst_stall_cnt", 32'(stall_cnt), 4);
    // reset inside LOCK with a write pending
    step(0, 0, 6'd0, 1, 6'd20, 1, 32'hCAFEF00D, 1, 0, 0, 1, 0);
    step(1, 1, 6'd21, 1, 6'd21, 1, 32'hFFFFFFFF, 1, 0, 0, 0, 1);
    chk("rl_locked", 32'(locked), 0);
    chk("rl_f_rsp_valid", 32'(f_rsp_valid), 0);
    chk("rl_l_rsp_valid", 32'(l_rsp_valid), 0);
    chk("rl_l_rsp_data", l_rsp_data, 0);
    chk("rl_no_write", mem[21], 0);
    step(0, 1, 6'd21, 0, 6'd0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 6'd20, 0, 6'd0, 0, 0, 0, 0, 1, 0, 0);
    // long lock with loader idle drives stall_cnt into saturation
    step(0, 1, 6'd30, 1, 6'd30, 1, 32'h0BADCAFE, 1, 0, 0, 1, 0);
    step(0, 1, 6'd30, 0, 6'd0, 0, 0, 0, 0, 0, 0, 1);
    repeat (65540) @(posedge clka);
    #1;
    chk("sat_stall_cnt", 32'(stall_cnt), 32'hFFFF);
    chk("sat_locked", 32'(locked), 1);
    step(0, 1, 6'd30, 0, 6'd0, 0, 0, 0, 1, 0, 0, 1);
    chk("sat_clr_stall_cnt", 32'(stall_cnt), 0);
    step(0, 1, 6'd30, 1, 6'd30, 0, 0, 0, 0, 0, 1, 1);
    step(0, 1, 6'd30, 0, 6'd0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 6'd0, 0, 6'd0, 0, 0, 0, 0, 0, 0, 0);
    chk("f_queue_drained", fq.size(), 0);
    chk("l_queue_drained", lq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end
endmodule
